// File: rtl/mem_flash_pkg.sv
// Shared constants, opcodes and FSM state encoding for the serial flash controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mem_flash_pkg;

    localparam int DEF_ADDR_WIDTH = 24;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_LEN_WIDTH  = 8;
    localparam int SHIFT_W        = 32;   // opcode + 24-bit address

    localparam logic [7:0] OP_SINGLE_WR = 8'h04;
    localparam logic [7:0] OP_BURST_WR  = 8'h02;
    localparam logic [7:0] OP_BURST_RD  = 8'h03;

    typedef enum logic [6:0] {
        S_IDLE    = 7'b000_0001,
        S_START   = 7'b000_0010,
        S_OPCODE  = 7'b000_0100,
        S_ADDRESS = 7'b000_1000,
        S_WR_DATA = 7'b001_0000,
        S_RD_DATA = 7'b010_0000,
        S_STOP    = 7'b100_0000
    } state_e;

    // Anything that is not a write opcode is executed as a burst read.
    function automatic logic is_write_op(input logic [7:0] op);
        return (op == OP_SINGLE_WR) || (op == OP_BURST_WR);
    endfunction

endpackage

// File: rtl/mem_flash_shifter.sv
// Loadable MSB-first shift register with serial input, shared by tx and rx paths.
// Latency: load or shift takes effect on the next clk_i edge; load wins over shift.
// Backpressure: none; the controller decides every cycle whether to load or shift.
// Ports: clk_i/rstn_i (sync active-low), load_i+load_dat_i, shift_i+ser_i,
//        msb_o (serial out), tail_o (low TAIL_W bits, used to assemble a read byte).
module mem_flash_shifter
    import mem_flash_pkg::*;
#(
    parameter int WIDTH  = SHIFT_W,
    parameter int TAIL_W = DEF_DATA_WIDTH - 1
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              load_i,
    input  logic [WIDTH-1:0]  load_dat_i,
    input  logic              shift_i,
    input  logic              ser_i,
    output logic              msb_o,
    output logic [TAIL_W-1:0] tail_o
);

    logic [WIDTH-1:0] sr_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= load_dat_i;
        end else if (shift_i) begin
            sr_q <= {sr_q[WIDTH-2:0], ser_i};
        end
    end

    assign msb_o  = sr_q[WIDTH-1];
    assign tail_o = sr_q[TAIL_W-1:0];

endmodule

// File: rtl/mem_flash_ctrl.sv
// Host-side serial flash controller: single write, burst write, burst read.
// Latency: Req accept to Done = 2*(33+8N)+3 cycles for N unstalled bytes; Sclk = Clk/2.
// Backpressure: write path stalls (Sclk low, Cen low) while Wr_valid=0 at a byte boundary;
//               read data has no backpressure.
// Ports: host side Req/Op/Addr/Len, Wr_data/Wr_valid/Wr_ready, Rd_data/Rd_valid, Busy/Done;
//        flash side Flash_cen/Flash_sclk/Flash_sin/Flash_sout.
module mem_flash_ctrl
    import mem_flash_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Rstn,
    input  logic                  Req,
    input  logic [7:0]            Op,
    input  logic [ADDR_WIDTH-1:0] Addr,
    input  logic [LEN_WIDTH-1:0]  Len,
    input  logic [DATA_WIDTH-1:0] Wr_data,
    input  logic                  Wr_valid,
    output logic                  Wr_ready,
    output logic [DATA_WIDTH-1:0] Rd_data,
    output logic                  Rd_valid,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Flash_cen,
    output logic                  Flash_sclk,
    output logic                  Flash_sin,
    input  logic                  Flash_sout
);

    state_e                state_q, state_d;
    logic                  phase_q, phase_d;    // 0 = L phase, 1 = H phase
    logic                  stall_q, stall_d;    // waiting for Wr_valid at a byte boundary
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [LEN_WIDTH-1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_op_q, wr_op_d;
    logic                  wr_ready_q, wr_ready_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  done_q, done_d;

    logic                  shf_load, shf_shift, shf_msb;
    logic [SHIFT_W-1:0]    shf_load_dat;
    logic [DATA_WIDTH-2:0] shf_tail;
    logic                  byte_start;
    logic                  last_bit, last_byte;

    assign last_bit  = (bit_cnt_q == 5'd0);
    assign last_byte = (byte_cnt_q == '0);

    mem_flash_shifter #(.WIDTH(SHIFT_W), .TAIL_W(DATA_WIDTH-1)) u_shifter (
        .clk_i      (Clk),
        .rstn_i     (Rstn),
        .load_i     (shf_load),
        .load_dat_i (shf_load_dat),
        .shift_i    (shf_shift),
        .ser_i      (Flash_sout),
        .msb_o      (shf_msb),
        .tail_o     (shf_tail)
    );

    always_ff @(posedge Clk) begin
        if (!Rstn) begin
            state_q    <= S_IDLE;
            phase_q    <= 1'b0;
            stall_q    <= 1'b0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            op_q       <= '0;
            addr_q     <= '0;
            wr_op_q    <= 1'b0;
            wr_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            stall_q    <= stall_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wr_op_q    <= wr_op_d;
            wr_ready_q <= wr_ready_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            done_q     <= done_d;
        end
    end

    // State changes and tx shifts happen on the H->L edge so Flash_sin is stable
    // across the rising Sclk edge; read capture happens on the L->H edge.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        stall_d      = stall_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wr_op_d      = wr_op_q;
        wr_ready_d   = 1'b0;
        rd_valid_d   = 1'b0;
        rd_data_d    = rd_data_q;
        done_d       = 1'b0;
        shf_load     = 1'b0;
        shf_load_dat = '0;
        shf_shift    = 1'b0;
        byte_start   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // done_q marks the cycle right after STOP, which does not accept requests.
                if (Req && !done_q) begin
                    state_d    = S_START;
                    phase_d    = 1'b0;
                    op_d       = Op;
                    addr_d     = Addr;
                    wr_op_d    = is_write_op(Op);
                    byte_cnt_d = (Op == OP_SINGLE_WR) ? '0 : Len;
                end
            end
            S_START: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    state_d      = S_OPCODE;
                    bit_cnt_d    = 5'd7;
                    shf_load     = 1'b1;
                    shf_load_dat = {op_q, addr_q};
                end
            end
            S_OPCODE: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    shf_shift = 1'b1;
                    if (last_bit) begin
                        state_d   = S_ADDRESS;
                        bit_cnt_d = 5'(ADDR_WIDTH - 1);
                    end else begin
                        bit_cnt_d = bit_cnt_q - 5'd1;
                    end
                end
            end
            S_ADDRESS: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (last_bit) begin
                        bit_cnt_d = 5'd7;
                        if (wr_op_q) begin
                            state_d    = S_WR_DATA;
                            byte_start = 1'b1;
                        end else begin
                            state_d = S_RD_DATA;
                        end
                    end else begin
                        shf_shift = 1'b1;
                        bit_cnt_d = bit_cnt_q - 5'd1;
                    end
                end
            end
            S_WR_DATA: begin
                if (stall_q) begin
                    byte_start = 1'b1;
                end else begin
                    phase_d = ~phase_q;
                    if (phase_q) begin
                        if (last_bit) begin
                            if (last_byte) begin
                                state_d = S_STOP;
                            end else begin
                                byte_cnt_d = byte_cnt_q - LEN_WIDTH'(1);
                                bit_cnt_d  = 5'd7;
                                byte_start = 1'b1;
                            end
                        end else begin
                            shf_shift = 1'b1;
                            bit_cnt_d = bit_cnt_q - 5'd1;
                        end
                    end
                end
            end
            S_RD_DATA: begin
                phase_d = ~phase_q;
                if (!phase_q) begin
                    shf_shift = 1'b1;
                    if (last_bit) begin
                        rd_data_d  = {shf_tail, Flash_sout};
                        rd_valid_d = 1'b1;
                    end
                end else if (last_bit) begin
                    if (last_byte) begin
                        state_d = S_STOP;
                    end else begin
                        byte_cnt_d = byte_cnt_q - LEN_WIDTH'(1);
                        bit_cnt_d  = 5'd7;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 5'd1;
                end
            end
            S_STOP: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = 1'b0;
                stall_d = 1'b0;
            end
        endcase

        // Entering bit 7 of a write byte: take the byte now or hold Sclk low until it arrives.
        if (byte_start) begin
            phase_d = 1'b0;
            if (Wr_valid) begin
                shf_load     = 1'b1;
                shf_load_dat = {Wr_data, {(SHIFT_W-DATA_WIDTH){1'b0}}};
                wr_ready_d   = 1'b1;
                stall_d      = 1'b0;
            end else begin
                stall_d = 1'b1;
            end
        end
    end

    assign Busy       = (state_q != S_IDLE);
    assign Done       = done_q;
    assign Wr_ready   = wr_ready_q;
    assign Rd_valid   = rd_valid_q;
    assign Rd_data    = rd_data_q;
    assign Flash_cen  = (state_q == S_IDLE) || (state_q == S_STOP);
    assign Flash_sclk = phase_q & ~stall_q;
    assign Flash_sin  = ((state_q == S_OPCODE) || (state_q == S_ADDRESS) ||
                         (state_q == S_WR_DATA)) & shf_msb;

endmodule

// File: tb/tb_mem_flash_ctrl.sv
// Self-checking bench for mem_flash_ctrl with a behavioural flash and a cycle timeline model.
module tb_mem_flash_ctrl;

    logic        Clk = 1'b0;
    logic        Rstn = 1'b0;
    logic        Req = 1'b0;
    logic [7:0]  Op = 8'h00;
    logic [23:0] Addr = 24'h0;
    logic [7:0]  Len = 8'h00;
    logic [7:0]  Wr_data = 8'h00;
    logic        Wr_valid = 1'b1;
    logic        Wr_ready, Rd_valid, Busy, Done, Flash_cen, Flash_sclk, Flash_sin;
    logic [7:0]  Rd_data;
    logic        Flash_sout = 1'b0;

    mem_flash_ctrl dut (
        .Clk(Clk), .Rstn(Rstn), .Req(Req), .Op(Op), .Addr(Addr), .Len(Len),
        .Wr_data(Wr_data), .Wr_valid(Wr_valid), .Wr_ready(Wr_ready),
        .Rd_data(Rd_data), .Rd_valid(Rd_valid), .Busy(Busy), .Done(Done),
        .Flash_cen(Flash_cen), .Flash_sclk(Flash_sclk), .Flash_sin(Flash_sin),
        .Flash_sout(Flash_sout)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // ---------------- behavioural flash: 1 KiB, address wraps at 1024 -------------
    logic [7:0]  fmem [0:1023];
    int          fl_cnt = 0;
    logic [7:0]  fl_op = 8'h00;
    logic [23:0] fl_addr = 24'h0;
    logic [7:0]  fl_sh = 8'h00;

    initial for (int i = 0; i < 1024; i++) fmem[i] = 8'(i ^ 8'h5A);

    always @(posedge Flash_cen) fl_cnt = 0;

    always @(posedge Flash_sclk) begin
        if (!Flash_cen) begin
            if (fl_cnt >= 1 && fl_cnt <= 8) fl_op = {fl_op[6:0], Flash_sin};
            else if (fl_cnt >= 9 && fl_cnt <= 32) fl_addr = {fl_addr[22:0], Flash_sin};
            else if (fl_cnt >= 33 && (fl_op == 8'h04 || fl_op == 8'h02)) begin
                fl_sh = {fl_sh[6:0], Flash_sin};
                if ((fl_cnt - 33) % 8 == 7)
                    fmem[(int'(fl_addr) + (fl_cnt - 33) / 8) & 1023] = fl_sh;
            end
            fl_cnt++;
        end
    end

    always @(negedge Flash_sclk) begin
        if (!Flash_cen && fl_cnt >= 33 && !(fl_op == 8'h04 || fl_op == 8'h02)) begin
            logic [7:0] b;
            b = fmem[(int'(fl_addr) + (fl_cnt - 33) / 8) & 1023];
            Flash_sout = b[7 - ((fl_cnt - 33) % 8)];
        end
    end

    // ---------------- expected timeline of the current transaction ----------------
    bit          e_act = 0;
    int          e_base, e_n, e_stall_k, e_stall_s;
    bit          e_wr;
    logic [7:0]  e_op;
    logic [23:0] e_addr;
    logic [7:0]  e_bytes [$];
    logic [7:0]  wq [$];
    logic [7:0]  rd_got [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic check_cycle();
        int n, p, t_act, sb, k;
        bit sin_chk, erv;
        logic eb, ec, es, ed, ewr, esin;
        logic [7:0] erd, cur;
        logic [31:0] hdr;
        eb = 0; ec = 1; es = 0; ed = 0; ewr = 0; erv = 0; esin = 0; sin_chk = 0; erd = 0;
        if (e_act) begin
            n = cyc - e_base;
            t_act = 2 * (33 + 8 * e_n);
            sb = 67 + 16 * e_stall_k;
            p = n;
            hdr = {e_op, e_addr};
            if (e_stall_s > 0 && n >= sb && n < sb + e_stall_s) begin
                eb = 1; ec = 0; es = 0;          // stalled: Sclk frozen low, Cen low
                p = -1;
            end else if (e_stall_s > 0 && n >= sb + e_stall_s) begin
                p = n - e_stall_s;
            end
            if (p >= 1 && p <= t_act) begin
                eb = 1; ec = 0; es = (p % 2 == 0);
                sin_chk = 1;
                if (p <= 2) esin = 0;
                else if (p <= 66) esin = hdr[31 - (p - 3) / 2];
                else if (e_wr) begin
                    cur = e_bytes[(p - 67) / 16];
                    esin = cur[7 - ((p - 67) % 16) / 2];
                end else sin_chk = 0;
                if (e_wr && p >= 67 && (p - 67) % 16 == 0) ewr = 1;
                if (!e_wr && p >= 82 && (p - 82) % 16 == 0) begin
                    k = (p - 82) / 16;
                    erv = 1; erd = e_bytes[k];
                end
            end else if (p == t_act + 1 || p == t_act + 2) begin
                eb = 1; ec = 1; es = (p == t_act + 2);
            end else if (p == t_act + 3) begin
                ed = 1;
            end
        end
        chk("busy", Busy, eb);
        chk("cen", Flash_cen, ec);
        chk("sclk", Flash_sclk, es);
        chk("done", Done, ed);
        chk("wr_ready", Wr_ready, ewr);
        chk("rd_valid", Rd_valid, erv);
        if (erv) chk("rd_data", Rd_data, erd);
        if (sin_chk) chk("sin", Flash_sin, esin);
    endtask

    task automatic tick();
        @(negedge Clk);
        check_cycle();
    endtask

    // rst_at > 0 pulls Rstn low after that cycle; exp_done = -1 means no Done expected.
    task automatic run_txn(input logic [7:0] op, input logic [23:0] addr, input logic [7:0] len,
                           input int stall_k, input int stall_s, input bit busy_req,
                           input int rst_at, input int exp_done);
        int n, t_act, sb, done_n, widx, last;
        e_op = op; e_addr = addr;
        e_wr = (op == 8'h04 || op == 8'h02);
        e_n = (op == 8'h04) ? 1 : int'(len) + 1;
        e_stall_k = stall_k;
        e_stall_s = (e_wr && stall_k < e_n) ? stall_s : 0;
        e_bytes.delete();
        rd_got.delete();
        for (int k = 0; k < e_n; k++)
            e_bytes.push_back(e_wr ? wq[k] : fmem[(int'(addr) + k) & 1023]);
        t_act = 2 * (33 + 8 * e_n);
        sb = 67 + 16 * e_stall_k;
        last = t_act + e_stall_s + 6;
        done_n = -1;
        widx = 0;
        Req = 1; Op = op; Addr = addr; Len = len; Wr_valid = 1;
        Wr_data = e_wr ? wq[0] : 8'h00;
        e_base = cyc; e_act = 1;
        for (int i = 0; i < last; i++) begin
            tick();
            n = cyc - e_base;
            Req = 0;
            Rstn = 1;
            if (rst_at > 0 && n == rst_at + 1) begin
                chk("rst_rd_data", Rd_data, 8'h00);
                chk("rst_sin", Flash_sin, 1'b0);
            end
            if (Done && done_n < 0) done_n = n;
            if (Rd_valid) rd_got.push_back(Rd_data);
            if (Wr_ready) widx++;
            if (e_wr && widx < e_n) Wr_data = wq[widx];
            Wr_valid = !(e_stall_s > 0 && n >= sb - 1 && n < sb - 1 + e_stall_s);
            if (busy_req && (n == 40 || n == t_act + 3 + e_stall_s)) begin
                Req = 1; Op = 8'h03; Addr = 24'h000ABC; Len = 8'd5;
            end
            if (rst_at > 0 && n == rst_at) begin
                Rstn = 0; e_act = 0;
            end
        end
        e_act = 0;
        chk("done_at", done_n, exp_done);
    endtask

    initial begin
        logic [7:0]  rop, rlen, keep;
        logic [23:0] raddr;
        int rn, rk, rs;

        Rstn = 0;
        repeat (3) tick();
        chk("reset_sin", Flash_sin, 1'b0);
        chk("reset_rd_data", Rd_data, 8'h00);
        Rstn = 1;
        tick();

        // single write; Len is ignored for 8'h04
        wq = '{8'hA5};
        run_txn(8'h04, 24'h000010, 8'h07, 0, 0, 0, 0, 85);
        chk("mem_010", fmem[16], 8'hA5);
        chk("mem_011_untouched", fmem[17], 8'(17 ^ 8'h5A));

        // burst write of three bytes
        wq = '{8'h11, 8'h22, 8'h33};
        run_txn(8'h02, 24'h000100, 8'd2, 0, 0, 0, 0, 117);
        chk("mem_100", fmem[256], 8'h11);
        chk("mem_101", fmem[257], 8'h22);
        chk("mem_102", fmem[258], 8'h33);

        // burst read back, with Req pulses while busy and during the Done cycle
        run_txn(8'h03, 24'h000100, 8'd2, 0, 0, 1, 0, 117);
        chk("rd_count", rd_got.size(), 3);
        if (rd_got.size() == 3) begin
            chk("rd_b0", rd_got[0], 8'h11);
            chk("rd_b1", rd_got[1], 8'h22);
            chk("rd_b2", rd_got[2], 8'h33);
        end

        // 10-cycle Wr_valid gap at the second byte
        wq = '{8'h5C, 8'hC5, 8'h3E};
        run_txn(8'h02, 24'h000200, 8'd2, 1, 10, 0, 0, 127);
        chk("stall_mem_200", fmem[512], 8'h5C);
        chk("stall_mem_201", fmem[513], 8'hC5);
        chk("stall_mem_202", fmem[514], 8'h3E);

        // reset during ADDRESS, then a clean single write
        keep = fmem[48];
        wq = '{8'hEE};
        run_txn(8'h04, 24'h000030, 8'd0, 0, 0, 0, 30, -1);
        chk("aborted_mem_030", fmem[48], keep);
        wq = '{8'h96};
        run_txn(8'h04, 24'h000020, 8'd0, 0, 0, 0, 0, 85);
        chk("post_rst_mem_020", fmem[32], 8'h96);

        // randomized transactions
        for (int r = 0; r < 10; r++) begin
            case ($urandom_range(0, 3))
                0: rop = 8'h04;
                1: rop = 8'h02;
                2: rop = 8'h03;
                default: rop = 8'hC7;
            endcase
            raddr = 24'($urandom);
            rlen = 8'($urandom_range(0, 3));
            rn = (rop == 8'h04) ? 1 : int'(rlen) + 1;
            wq.delete();
            for (int k = 0; k < 4; k++) wq.push_back(8'($urandom));
            rk = 0; rs = 0;
            if ((rop == 8'h04 || rop == 8'h02) && $urandom_range(0, 1) == 1) begin
                rk = $urandom_range(0, rn - 1);
                rs = $urandom_range(1, 6);
            end
            run_txn(rop, raddr, rlen, rk, rs, 0, 0, 2 * (33 + 8 * rn) + 3 + rs);
            if (rop == 8'h04 || rop == 8'h02)
                for (int k = 0; k < rn; k++)
                    chk("rand_mem", fmem[(int'(raddr) + k) & 1023], wq[k]);
            else
                chk("rand_rd_count", rd_got.size(), rn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
